// File: rtl/tmds_video_timing_pkg.sv
// rtl/tmds_video_timing_pkg.sv - shared types and constants for the TMDS video timing tracker
package tmds_video_timing_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        FRAME      = 2'd2
    } vt_state_e;

    localparam int SYNC_H     = 0;
    localparam int SYNC_V     = 1;
    localparam int DEF_X_BITS = 12;
    localparam int DEF_Y_BITS = 11;

endpackage

// File: rtl/tmds_geometry_lock.sv
// rtl/tmds_geometry_lock.sv - frame geometry register, stability counter and timing lock flag
module tmds_geometry_lock #(
    parameter int X_BITS      = 12,
    parameter int Y_BITS      = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              meas_stb,
    input  logic              meas_bad,
    input  logic              meas_has_lines,
    input  logic [X_BITS-1:0] meas_w,
    input  logic [Y_BITS-1:0] meas_h,
    output logic [X_BITS-1:0] width,
    output logic [Y_BITS-1:0] height,
    output logic              timing_locked
);

    localparam int CW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_FRAMES);

    logic [CW-1:0] match_cnt;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = match_cnt;
        if (meas_stb) begin
            if (!meas_has_lines) begin
                cnt_d = '0;
            end else if (!meas_bad && meas_w == width && meas_h == height) begin
                cnt_d = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + CW'(1);
            end else begin
                // A clean frame with new geometry counts as the first of a new run
                cnt_d = meas_bad ? '0 : CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt     <= '0;
            timing_locked <= 1'b0;
            width         <= '0;
            height        <= '0;
        end else if (clear) begin
            match_cnt     <= '0;
            timing_locked <= 1'b0;
        end else begin
            match_cnt     <= cnt_d;
            timing_locked <= (cnt_d >= CNT_MAX);
            if (meas_stb && meas_has_lines) begin
                width  <= meas_w;
                height <= meas_h;
            end
        end
    end

endmodule

// File: rtl/tmds_video_timing.sv
// rtl/tmds_video_timing.sv - turns decoded TMDS strobes into registered RGB, de, x/y and frame geometry
module tmds_video_timing
    import tmds_video_timing_pkg::*;
#(
    parameter int X_BITS      = DEF_X_BITS,
    parameter int Y_BITS      = DEF_Y_BITS,
    parameter int MIN_WIDTH   = 16,
    parameter int LOCK_FRAMES = 2,
    parameter int VSYNC_POL   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked,
    input  logic              data_valid,
    input  logic              sync_valid,
    input  logic [1:0]        sync,
    input  logic [7:0]        d0,
    input  logic [7:0]        d1,
    input  logic [7:0]        d2,
    output logic              de,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              line_start,
    output logic              frame_start,
    output logic [X_BITS-1:0] width,
    output logic [Y_BITS-1:0] height,
    output logic              timing_locked
);

    localparam logic VS_LVL = VSYNC_POL[0];
    localparam logic [X_BITS:0] MIN_LEN = (X_BITS + 1)'(MIN_WIDTH);

    vt_state_e state_q, state_d;

    logic              vs_act_q;
    logic              in_run_q;
    logic              frame_bad_q;
    logic [X_BITS:0]   line_w_q;

    logic              sync_upd;
    logic              vs_new;
    logic              vs_edge;
    logic              run_end;
    logic              run_ok;
    logic              first_line;
    logic              y_full;
    logic [X_BITS:0]   run_len;
    logic [X_BITS:0]   line_w_eff;
    logic [Y_BITS-1:0] y_eff;
    logic              bad_eff;
    logic              meas_stb;
    logic              meas_has_lines;
    logic [X_BITS-1:0] meas_w;
    logic              unused_hsync;

    assign unused_hsync = sync[SYNC_H];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (locked) state_d = WAIT_VSYNC;
            WAIT_VSYNC: if (vs_edge) state_d = FRAME;
            FRAME:      state_d = FRAME;
            default:    state_d = IDLE;
        endcase
        if (!locked) state_d = IDLE;
    end

    // Run-end bookkeeping is resolved combinationally so a vsync edge that
    // lands on the first blanking cycle still sees the line that just ended.
    always_comb begin
        sync_upd       = sync_valid && !data_valid;
        vs_new         = (sync[SYNC_V] == VS_LVL);
        vs_edge        = sync_upd && vs_new && !vs_act_q;
        run_end        = (state_q == FRAME) && in_run_q && !data_valid;
        run_len        = {1'b0, x} + (X_BITS + 1)'(1);
        run_ok         = run_end && (run_len >= MIN_LEN);
        first_line     = (y == '0);
        y_full         = (y == '1);
        y_eff          = (run_ok && !y_full) ? y + Y_BITS'(1) : y;
        line_w_eff     = (run_ok && first_line) ? run_len : line_w_q;
        bad_eff        = frame_bad_q
                       | (run_ok && !first_line && (run_len != line_w_q))
                       | (run_ok && y_full);
        meas_stb       = (state_q == FRAME) && vs_edge && locked;
        meas_has_lines = (y_eff != '0);
        meas_w         = line_w_eff[X_BITS] ? '1 : line_w_eff[X_BITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vs_act_q    <= 1'b0;
            in_run_q    <= 1'b0;
            frame_bad_q <= 1'b0;
            line_w_q    <= '0;
        end else begin
            r           <= d2;
            g           <= d1;
            b           <= d0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (sync_upd) vs_act_q <= vs_new;

            if (!locked) begin
                in_run_q    <= 1'b0;
                x           <= '0;
                y           <= '0;
                line_w_q    <= '0;
                frame_bad_q <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_VSYNC: begin
                        if (vs_edge) begin
                            frame_start <= 1'b1;
                            in_run_q    <= 1'b0;
                            y           <= '0;
                            line_w_q    <= '0;
                            frame_bad_q <= 1'b0;
                        end
                    end
                    FRAME: begin
                        in_run_q <= data_valid;
                        if (data_valid) begin
                            de <= 1'b1;
                            if (!in_run_q) begin
                                x          <= '0;
                                line_start <= 1'b1;
                            end else if (x == '1) begin
                                frame_bad_q <= 1'b1;
                            end else begin
                                x <= x + X_BITS'(1);
                            end
                        end else if (vs_edge) begin
                            frame_start <= 1'b1;
                            y           <= '0;
                            line_w_q    <= '0;
                            frame_bad_q <= 1'b0;
                        end else if (run_end) begin
                            y           <= y_eff;
                            line_w_q    <= line_w_eff;
                            frame_bad_q <= bad_eff;
                        end
                    end
                    default: begin
                        in_run_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    tmds_geometry_lock #(
        .X_BITS      (X_BITS),
        .Y_BITS      (Y_BITS),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_geometry_lock (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (!locked),
        .meas_stb       (meas_stb),
        .meas_bad       (bad_eff),
        .meas_has_lines (meas_has_lines),
        .meas_w         (meas_w),
        .meas_h         (y_eff),
        .width          (width),
        .height         (height),
        .timing_locked  (timing_locked)
    );

endmodule

// File: tb/tb_tmds_video_timing.sv
// tb/tb_tmds_video_timing.sv - scoreboard bench for tmds_video_timing
module tb_tmds_video_timing;
    import tmds_video_timing_pkg::*;

    localparam int XB  = 12;
    localparam int YB  = 11;
    localparam int XBS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic locked = 1'b0;
    logic data_valid = 1'b0;
    logic sync_valid = 1'b0;
    logic [1:0] sync = 2'b00;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;

    logic de, line_start, frame_start, timing_locked;
    logic [7:0] r, g, b;
    logic [XB-1:0] x, width;
    logic [YB-1:0] y, height;

    logic de_s, line_start_s, frame_start_s, timing_locked_s;
    logic [7:0] r_s, g_s, b_s;
    logic [XBS-1:0] x_s, width_s;
    logic [YB-1:0] y_s, height_s;

    tmds_video_timing #(.X_BITS(XB), .Y_BITS(YB), .MIN_WIDTH(4), .LOCK_FRAMES(2), .VSYNC_POL(1)) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .data_valid(data_valid),
        .sync_valid(sync_valid), .sync(sync), .d0(d0), .d1(d1), .d2(d2),
        .de(de), .r(r), .g(g), .b(b), .x(x), .y(y), .line_start(line_start),
        .frame_start(frame_start), .width(width), .height(height),
        .timing_locked(timing_locked));

    tmds_video_timing #(.X_BITS(XBS), .Y_BITS(YB), .MIN_WIDTH(4), .LOCK_FRAMES(2), .VSYNC_POL(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .locked(locked), .data_valid(data_valid),
        .sync_valid(sync_valid), .sync(sync), .d0(d0), .d1(d1), .d2(d2),
        .de(de_s), .r(r_s), .g(g_s), .b(b_s), .x(x_s), .y(y_s), .line_start(line_start_s),
        .frame_start(frame_start_s), .width(width_s), .height(height_s),
        .timing_locked(timing_locked_s));

    always #5 clk = ~clk;

    typedef struct {
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic          ls;
        logic [7:0]    r, g, b;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   ls_cnt = 0;
    bit   push_en = 1'b0;

    always @(negedge clk) begin
        if (line_start) ls_cnt++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (de !== 1'b1 || x !== mon_e.x || y !== mon_e.y || line_start !== mon_e.ls ||
                r !== mon_e.r || g !== mon_e.g || b !== mon_e.b) begin
                n_fail++;
                $display("FAIL pixel: got de=%0b x=%0d y=%0d ls=%0b rgb=%h/%h/%h, expected de=1 x=%0d y=%0d ls=%0b rgb=%h/%h/%h",
                         de, x, y, line_start, r, g, b, mon_e.x, mon_e.y, mon_e.ls, mon_e.r, mon_e.g, mon_e.b);
            end
        end else if (de !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_de: got de=%0b x=%0d y=%0d, expected de=0", de, x, y);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b0;
            sync_valid = 1'b1;
            sync       = 2'b00;
            step();
        end
    endtask

    task automatic send_line(input int n, input int yexp, input bit chk_sat);
        pix_t e;
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1;
            sync_valid = 1'b0;
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            e.x = XB'(i);
            e.y = YB'(yexp);
            e.ls = (i == 0);
            e.r = d2;
            e.g = d1;
            e.b = d0;
            @(posedge clk);
            if (push_en) exp_q.push_back(e);
            #1;
            if (chk_sat) begin
                n_tests++;
                if (x_s !== XBS'((i > 7) ? 7 : i)) begin
                    n_fail++;
                    $display("FAIL x_saturate: got x=%0d, expected %0d", x_s, (i > 7) ? 7 : i);
                end
            end
        end
        blank(2);
    endtask

    task automatic send_frame(input int npix, input int bad_line, input int bad_len,
                              input bit glitch, input bit chk_sat);
        for (int l = 0; l < 3; l++) begin
            send_line((l == bad_line) ? bad_len : npix, l, chk_sat);
            if (glitch && l == 1) send_line(2, 2, 1'b0);
        end
    endtask

    task automatic end_frame(input string tag, input int ew, input int eh, input bit el, input int els);
        data_valid = 1'b0;
        sync_valid = 1'b1;
        sync       = 2'b10;
        step();
        n_tests++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame_start: got %0b expected 1", tag, frame_start);
        end
        n_tests++;
        if (width !== XB'(ew)) begin
            n_fail++;
            $display("FAIL %s width: got %0d expected %0d", tag, width, ew);
        end
        n_tests++;
        if (height !== YB'(eh)) begin
            n_fail++;
            $display("FAIL %s height: got %0d expected %0d", tag, height, eh);
        end
        n_tests++;
        if (timing_locked !== el) begin
            n_fail++;
            $display("FAIL %s timing_locked: got %0b expected %0b", tag, timing_locked, el);
        end
        if (els >= 0) begin
            n_tests++;
            if (ls_cnt != els) begin
                n_fail++;
                $display("FAIL %s line_start_count: got %0d expected %0d", tag, ls_cnt, els);
            end
        end
        ls_cnt = 0;
        sync = 2'b00;
        step();
        n_tests++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s frame_start_pulse: got %0b expected 0", tag, frame_start);
        end
        blank(1);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        locked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            sync_valid = 1'b0;
            d0 = 8'($urandom | 1);
            d1 = 8'($urandom | 1);
            d2 = 8'($urandom | 1);
            step();
        end
        n_tests++;
        if ({de, r, g, b, x, y, line_start, frame_start, width, height, timing_locked} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got de=%0b rgb=%h/%h/%h x=%0d y=%0d w=%0d h=%0d lock=%0b, expected all 0",
                     de, r, g, b, x, y, width, height, timing_locked);
        end
        rst_n = 1'b1;
        blank(1);
        n_tests++;
        if (dut.state_q !== WAIT_VSYNC) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, WAIT_VSYNC);
        end
        blank(2);
    endtask

    task automatic test_frames();
        push_en = 1'b1;
        end_frame("enter", 0, 0, 1'b0, -1);
        send_frame(8, -1, 0, 1'b0, 1'b0);
        end_frame("f1", 8, 3, 1'b0, 3);
        send_frame(8, -1, 0, 1'b0, 1'b0);
        end_frame("f2", 8, 3, 1'b1, 3);
    endtask

    task automatic test_glitch();
        send_frame(8, -1, 0, 1'b1, 1'b0);
        end_frame("glitch", 8, 3, 1'b1, 4);
    endtask

    task automatic test_bad_line();
        send_frame(8, 1, 9, 1'b0, 1'b0);
        end_frame("bad", 8, 3, 1'b0, 3);
        send_frame(8, -1, 0, 1'b0, 1'b0);
        end_frame("rec1", 8, 3, 1'b0, 3);
        send_frame(8, -1, 0, 1'b0, 1'b0);
        end_frame("rec2", 8, 3, 1'b1, 3);
    endtask

    task automatic test_unlock();
        send_line(8, 0, 1'b0);
        push_en    = 1'b0;
        locked     = 1'b0;
        data_valid = 1'b1;
        sync_valid = 1'b0;
        step();
        n_tests++;
        if (de !== 1'b0 || timing_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL unlock_flags: got de=%0b lock=%0b expected 0/0", de, timing_locked);
        end
        n_tests++;
        if (width !== XB'(8) || height !== YB'(3)) begin
            n_fail++;
            $display("FAIL unlock_geometry: got %0d/%0d expected 8/3", width, height);
        end
        locked = 1'b1;
        for (int i = 0; i < 3; i++) step();
        blank(2);
        send_line(8, 1, 1'b0);
        send_line(8, 2, 1'b0);
        push_en = 1'b1;
        end_frame("relock", 8, 3, 1'b0, -1);
        send_frame(8, -1, 0, 1'b0, 1'b0);
        end_frame("u1", 8, 3, 1'b0, 3);
        send_frame(8, -1, 0, 1'b0, 1'b0);
        end_frame("u2", 8, 3, 1'b1, 3);
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 3; f++) begin
            send_frame(10, -1, 0, 1'b0, 1'b1);
            end_frame("sat", 10, 3, (f > 0), 3);
            n_tests++;
            if (timing_locked_s !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_lock frame %0d: got %0b expected 0", f, timing_locked_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_glitch();
        test_bad_line();
        test_unlock();
        test_saturation();
        blank(3);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending pixels expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
